// File: rtl/tb_uart_tx.sv
// tb_uart_tx: byte-wide FIFO feeding an 8N1 UART transmitter that is
// throttled by an active-low clear-to-send input.
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        synchronous active-high reset
//   i_wr_valid   byte-write request
//   i_wr_data    byte to queue
//   o_wr_ready   FIFO not full (depends only on registered count)
//   i_cts_n      clear-to-send, active-low, looked at only between frames
//   o_txd        registered serial output, idle high
//   o_busy       high while a frame is on the line
//   o_fifo_count bytes waiting in the FIFO (the byte on the line is excluded)
module tb_uart_tx #(
  parameter int CLK_DIV = 87,
  parameter int FIFO_AW = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_valid,
  input  logic [7:0]         i_wr_data,
  output logic               o_wr_ready,
  input  logic               i_cts_n,
  output logic               o_txd,
  output logic               o_busy,
  output logic [FIFO_AW:0]   o_fifo_count
);
  localparam int               DEPTH  = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0]      DIV_M1 = 16'(CLK_DIV-1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [15:0]        div_q, div_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         sh_q, sh_d;
  logic               txd_q, txd_d;
  logic               push, pop, bit_end;

  assign o_wr_ready   = (cnt_q != FULL);
  assign push         = i_wr_valid && o_wr_ready;
  // CTS only matters here: once a frame has left IDLE it always completes.
  assign pop          = (state_q == IDLE) && (cnt_q != '0) && !i_cts_n;
  assign bit_end      = (div_q == DIV_M1);
  assign o_txd        = txd_q;
  assign o_busy       = (state_q != IDLE);
  assign o_fifo_count = cnt_q;

  // ---------------- FIFO ----------------
  // Storage is not reset: clearing the pointers is enough to discard it.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= i_wr_data;
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;      // none, or push+pop together
    endcase
  end

  // ---------------- transmitter FSM ----------------
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          state_d = START;
          div_d   = '0;
          idx_d   = '0;
          sh_d    = mem_q[rptr_q];
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          div_d   = '0;
          txd_d   = sh_q[0];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];        // next bit, ahead of the shift
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
